// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter of icache/dcache line misses onto one L2 port
//
// Single-outstanding, non-pipelined arbiter. One grant is served at a time; a
// mandatory IDLE cycle separates grants so the served requester can drop its
// request before the next arbitration.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   icache_pmem_*              icache line-fill request / response
//   dcache_pmem_*              dcache line-fill or writeback request / response
//   l2_*                       single L2 port (strobes held until l2_resp)
//   arb_conflict_count         saturating count of IDLE cycles with both requesting
module cache_arbiter #(
   parameter int LINE_WIDTH = 128,
   parameter int ADDR_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  icache_pmem_read,
   input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
   output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
   output logic                  icache_pmem_resp,
   input  logic                  dcache_pmem_read,
   input  logic                  dcache_pmem_write,
   input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
   input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
   output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
   output logic                  dcache_pmem_resp,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [ADDR_WIDTH-1:0] l2_address,
   output logic [LINE_WIDTH-1:0] l2_wdata,
   input  logic [LINE_WIDTH-1:0] l2_rdata,
   input  logic                  l2_resp,
   output logic [CNT_WIDTH-1:0]  arb_conflict_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   state_e               state_q, state_d;
   logic                 last_d_q, last_d_d;   // 1: most recent grant went to dcache
   logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;
   logic                 req_i, req_d;

   assign req_i = icache_pmem_read;
   assign req_d = dcache_pmem_read | dcache_pmem_write;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         last_d_q       <= 1'b0;
         conflict_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         last_d_q       <= last_d_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d        = state_q;
      last_d_d       = last_d_q;
      conflict_cnt_d = conflict_cnt_q;
      case (state_q)
         IDLE: begin
            if (req_i && req_d) begin
               // Tie: grant whoever did not win last time
               state_d = last_d_q ? SERVE_I : SERVE_D;
               if (conflict_cnt_q != '1) begin
                  conflict_cnt_d = conflict_cnt_q + CNT_ONE;
               end
            end else if (req_i) begin
               state_d = SERVE_I;
            end else if (req_d) begin
               state_d = SERVE_D;
            end
            if (state_d != IDLE) begin
               last_d_d = (state_d == SERVE_D);
            end
         end
         SERVE_I, SERVE_D: begin
            if (l2_resp) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: strobes and responses gated by the registered state only
   always_comb begin
      l2_read          = 1'b0;
      l2_write         = 1'b0;
      l2_address       = icache_pmem_address;
      icache_pmem_resp = 1'b0;
      dcache_pmem_resp = 1'b0;
      case (state_q)
         SERVE_I: begin
            l2_read          = 1'b1;
            icache_pmem_resp = l2_resp;
         end
         SERVE_D: begin
            l2_read          = dcache_pmem_read;
            l2_write         = dcache_pmem_write;
            l2_address       = dcache_pmem_address;
            dcache_pmem_resp = l2_resp;
         end
         default: ;
      endcase
   end

   // Write data only matters to L2 while serving dcache, so no mux is needed
   assign l2_wdata           = dcache_pmem_wdata;
   assign icache_pmem_rdata  = l2_rdata;
   assign dcache_pmem_rdata  = l2_rdata;
   assign arb_conflict_count = conflict_cnt_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
module tb_cache_arbiter;

   localparam int LW      = 128;
   localparam int AW      = 16;
   localparam int CW      = 10;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          icache_pmem_read;
   logic [AW-1:0] icache_pmem_address;
   logic [LW-1:0] icache_pmem_rdata;
   logic          icache_pmem_resp;
   logic          dcache_pmem_read;
   logic          dcache_pmem_write;
   logic [AW-1:0] dcache_pmem_address;
   logic [LW-1:0] dcache_pmem_wdata;
   logic [LW-1:0] dcache_pmem_rdata;
   logic          dcache_pmem_resp;
   logic          l2_read;
   logic          l2_write;
   logic [AW-1:0] l2_address;
   logic [LW-1:0] l2_wdata;
   logic [LW-1:0] l2_rdata;
   logic          l2_resp;
   logic [CW-1:0] arb_conflict_count;

   int vectors;
   int miscompares;

   // Reference model: who is being served (0 none, 1 icache, 2 dcache),
   // whether the last grant went to dcache, and the tie count.
   int m_srv;
   bit m_last_d;
   int m_cnt;

   always #5 clk = ~clk;

   cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk                 (clk),
      .reset               (reset),
      .icache_pmem_read    (icache_pmem_read),
      .icache_pmem_address (icache_pmem_address),
      .icache_pmem_rdata   (icache_pmem_rdata),
      .icache_pmem_resp    (icache_pmem_resp),
      .dcache_pmem_read    (dcache_pmem_read),
      .dcache_pmem_write   (dcache_pmem_write),
      .dcache_pmem_address (dcache_pmem_address),
      .dcache_pmem_wdata   (dcache_pmem_wdata),
      .dcache_pmem_rdata   (dcache_pmem_rdata),
      .dcache_pmem_resp    (dcache_pmem_resp),
      .l2_read             (l2_read),
      .l2_write            (l2_write),
      .l2_address          (l2_address),
      .l2_wdata            (l2_wdata),
      .l2_rdata            (l2_rdata),
      .l2_resp             (l2_resp),
      .arb_conflict_count  (arb_conflict_count)
   );

   always @(posedge clk) begin
      if (!reset) begin
         assert (!(dcache_pmem_read && dcache_pmem_write))
            else $error("illegal dcache read and write together");
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      icache_pmem_read    = 1'b0;
      icache_pmem_address = '0;
      dcache_pmem_read    = 1'b0;
      dcache_pmem_write   = 1'b0;
      dcache_pmem_address = '0;
      dcache_pmem_wdata   = '0;
      l2_rdata            = '0;
      l2_resp             = 1'b0;
   endtask

   task automatic model_reset();
      m_srv    = 0;
      m_last_d = 1'b0;
      m_cnt    = 0;
   endtask

   // Advance the model by the rules for one clock using the current inputs,
   // then move to the next negedge.
   task automatic model_step();
      bit ri, rd;
      ri = icache_pmem_read;
      rd = dcache_pmem_read | dcache_pmem_write;
      if (reset) begin
         model_reset();
      end else if (m_srv == 0) begin
         if (ri && rd) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_srv = m_last_d ? 1 : 2;
         end else if (ri) begin
            m_srv = 1;
         end else if (rd) begin
            m_srv = 2;
         end
         if (m_srv != 0) m_last_d = (m_srv == 2);
      end else if (l2_resp) begin
         m_srv = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      icache_pmem_read  = 1'b1;
      dcache_pmem_write = 1'b1;
      l2_resp           = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if ({l2_read, l2_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b want 0000",
                  {l2_read, l2_write, icache_pmem_resp, dcache_pmem_resp});
      end
      vectors++;
      if (arb_conflict_count !== '0) begin
         miscompares++;
         $display("FAIL reset_count: got %0d want 0", arb_conflict_count);
      end
      do_reset();
   endtask

   task automatic test_icache_read();
      logic [LW-1:0] line;
      line = {16'hDEAD, 96'h0123_4567_89AB_CDEF_0011_2233, 16'hBEEF};
      do_reset();
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 16'h1230;
      #1;
      vectors++;
      if (l2_read !== 1'b0) begin
         miscompares++;
         $display("FAIL icache_idle_strobe: got %b want 0", l2_read);
      end
      model_step();
      #1;
      vectors++;
      if ({l2_read, l2_write} !== 2'b10 || l2_address !== 16'h1230) begin
         miscompares++;
         $display("FAIL icache_strobe: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=1230",
                  l2_read, l2_write, l2_address);
      end
      model_step();
      l2_resp  = 1'b1;
      l2_rdata = line;
      #1;
      vectors++;
      if (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0) begin
         miscompares++;
         $display("FAIL icache_resp: got i=%b d=%b want i=1 d=0", icache_pmem_resp, dcache_pmem_resp);
      end
      vectors++;
      if (icache_pmem_rdata !== line) begin
         miscompares++;
         $display("FAIL icache_rdata: got %h want %h", icache_pmem_rdata, line);
      end
      model_step();
      icache_pmem_read = 1'b0;
      l2_resp          = 1'b0;
      #1;
      vectors++;
      if ({l2_read, icache_pmem_resp} !== 2'b00) begin
         miscompares++;
         $display("FAIL icache_back_idle: got rd=%b resp=%b want 0 0", l2_read, icache_pmem_resp);
      end
   endtask

   task automatic test_dcache_write();
      logic [LW-1:0] pat;
      pat = {16{8'hA5}};
      do_reset();
      dcache_pmem_write   = 1'b1;
      dcache_pmem_address = 16'h4000;
      dcache_pmem_wdata   = pat;
      #1;
      model_step();
      for (int c = 0; c < 2; c++) begin
         #1;
         vectors++;
         if ({l2_read, l2_write} !== 2'b01 || l2_address !== 16'h4000 || l2_wdata !== pat) begin
            miscompares++;
            $display("FAIL dcache_write_strobe: got rd=%b wr=%b addr=%h wdata=%h",
                     l2_read, l2_write, l2_address, l2_wdata);
         end
         vectors++;
         if (dcache_pmem_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL dcache_early_resp: got %b want 0", dcache_pmem_resp);
         end
         model_step();
      end
      l2_resp = 1'b1;
      #1;
      vectors++;
      if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0) begin
         miscompares++;
         $display("FAIL dcache_resp: got d=%b i=%b want d=1 i=0", dcache_pmem_resp, icache_pmem_resp);
      end
      model_step();
      dcache_pmem_write = 1'b0;
      #1;
      vectors++;
      if (dcache_pmem_resp !== 1'b0 || l2_write !== 1'b0) begin
         miscompares++;
         $display("FAIL dcache_resp_one_cycle: got resp=%b wr=%b want 0 0", dcache_pmem_resp, l2_write);
      end
      l2_resp = 1'b0;
      model_step();
   endtask

   task automatic test_tie();
      do_reset();
      icache_pmem_read    = 1'b1;
      icache_pmem_address = 16'h1230;
      dcache_pmem_read    = 1'b1;
      dcache_pmem_address = 16'h4000;
      #1;
      model_step();
      #1;
      vectors++;
      if (l2_read !== 1'b1 || l2_address !== 16'h4000) begin
         miscompares++;
         $display("FAIL tie_first_d: got rd=%b addr=%h want rd=1 addr=4000", l2_read, l2_address);
      end
      l2_resp = 1'b1;
      #1;
      vectors++;
      if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0) begin
         miscompares++;
         $display("FAIL tie_d_resp: got d=%b i=%b want d=1 i=0", dcache_pmem_resp, icache_pmem_resp);
      end
      model_step();
      dcache_pmem_read = 1'b0;
      l2_resp          = 1'b0;
      #1;
      vectors++;
      if (l2_read !== 1'b0 || arb_conflict_count !== CW'(1)) begin
         miscompares++;
         $display("FAIL tie_idle_gap: got rd=%b cnt=%0d want rd=0 cnt=1", l2_read, arb_conflict_count);
      end
      model_step();
      #1;
      vectors++;
      if (l2_read !== 1'b1 || l2_address !== 16'h1230) begin
         miscompares++;
         $display("FAIL tie_then_i: got rd=%b addr=%h want rd=1 addr=1230", l2_read, l2_address);
      end
      l2_resp = 1'b1;
      model_step();
      l2_resp          = 1'b0;
      dcache_pmem_read = 1'b1;
      #1;
      model_step();
      #1;
      vectors++;
      if (l2_address !== 16'h4000 || arb_conflict_count !== CW'(2)) begin
         miscompares++;
         $display("FAIL tie_second: got addr=%h cnt=%0d want addr=4000 cnt=2", l2_address, arb_conflict_count);
      end
      l2_resp = 1'b1;
      model_step();
      clear_inputs();
      model_step();
   endtask

   task automatic test_alternate();
      int  grants;
      int  busy;
      int  n_i, n_d;
      bit  bump_i, bump_d;
      bit  want_d;
      do_reset();
      grants = 0; busy = 0; n_i = 0; n_d = 0; bump_i = 0; bump_d = 0;
      for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
         if (bump_i) n_i++;
         if (bump_d) n_d++;
         bump_i = 0; bump_d = 0;
         icache_pmem_read    = 1'b1;
         dcache_pmem_read    = 1'b1;
         icache_pmem_address = AW'(16'h1000 + n_i);
         dcache_pmem_address = AW'(16'h4000 + n_d);
         l2_resp             = (busy == 2);
         #1;
         if (l2_read || l2_write) begin
            if (busy == 0) begin
               want_d = (grants % 2 == 0);
               vectors++;
               if (l2_address !== (want_d ? AW'(16'h4000 + n_d) : AW'(16'h1000 + n_i))) begin
                  miscompares++;
                  $display("FAIL alternate_grant%0d: got addr=%h want %s", grants, l2_address,
                           want_d ? "dcache" : "icache");
               end
               grants++;
               vectors++;
               if (arb_conflict_count !== CW'(grants)) begin
                  miscompares++;
                  $display("FAIL alternate_count: got %0d want %0d", arb_conflict_count, grants);
               end
            end
            busy++;
            if (l2_resp) begin
               busy   = 0;
               bump_i = icache_pmem_resp;
               bump_d = dcache_pmem_resp;
            end
         end
         model_step();
      end
      vectors++;
      if (grants < 10) begin
         miscompares++;
         $display("FAIL alternate_timeout: got %0d grants want 10", grants);
      end
      clear_inputs();
      do_reset();
   endtask

   task automatic test_reset_midflight();
      do_reset();
      dcache_pmem_write   = 1'b1;
      dcache_pmem_address = 16'h4000;
      dcache_pmem_wdata   = {16{8'h5A}};
      #1;
      model_step();
      for (int c = 0; c < 2; c++) begin
         #1;
         vectors++;
         if (l2_write !== 1'b1) begin
            miscompares++;
            $display("FAIL midflight_pending: got wr=%b want 1", l2_write);
         end
         if (c == 0) model_step();
      end
      l2_resp = 1'b1;
      reset   = 1'b1;
      #1;
      model_reset();
      vectors++;
      if ({l2_read, l2_write, dcache_pmem_resp, icache_pmem_resp} !== 4'b0000) begin
         miscompares++;
         $display("FAIL midflight_async: got %b want 0000",
                  {l2_read, l2_write, dcache_pmem_resp, icache_pmem_resp});
      end
      dcache_pmem_write = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if ({l2_read, l2_write, dcache_pmem_resp, icache_pmem_resp} !== 4'b0000) begin
         miscompares++;
         $display("FAIL midflight_late_resp: got %b want 0000",
                  {l2_read, l2_write, dcache_pmem_resp, icache_pmem_resp});
      end
      model_step();
      l2_resp = 1'b0;
      #1;
      vectors++;
      if (l2_read !== 1'b0 || l2_write !== 1'b0 || arb_conflict_count !== '0) begin
         miscompares++;
         $display("FAIL midflight_idle: got rd=%b wr=%b cnt=%0d want 0 0 0", l2_read, l2_write, arb_conflict_count);
      end
   endtask

   task automatic test_random();
      bit i_act, d_act, d_wr;
      bit exp_rd, exp_wr, exp_ir, exp_dr;
      do_reset();
      i_act = 0; d_act = 0; d_wr = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!i_act && $urandom_range(0, 2) == 0) begin
            i_act = 1;
            icache_pmem_address = AW'($urandom);
         end
         if (!d_act && $urandom_range(0, 2) == 0) begin
            d_act = 1;
            d_wr  = $urandom_range(0, 1) == 1;
            dcache_pmem_address = AW'($urandom);
            dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
         end
         icache_pmem_read  = i_act;
         dcache_pmem_read  = d_act && !d_wr;
         dcache_pmem_write = d_act && d_wr;
         l2_resp           = $urandom_range(0, 2) == 0;
         l2_rdata          = {$urandom, $urandom, $urandom, $urandom};
         #1;
         exp_rd = (m_srv == 1) || (m_srv == 2 && dcache_pmem_read);
         exp_wr = (m_srv == 2) && dcache_pmem_write;
         exp_ir = (m_srv == 1) && l2_resp;
         exp_dr = (m_srv == 2) && l2_resp;
         vectors++;
         if ({l2_read, l2_write, icache_pmem_resp, dcache_pmem_resp} !== {exp_rd, exp_wr, exp_ir, exp_dr}) begin
            miscompares++;
            $display("FAIL random_ctrl cyc%0d: got %b want %b", cyc,
                     {l2_read, l2_write, icache_pmem_resp, dcache_pmem_resp}, {exp_rd, exp_wr, exp_ir, exp_dr});
         end
         if (m_srv != 0) begin
            vectors++;
            if (l2_address !== (m_srv == 2 ? dcache_pmem_address : icache_pmem_address)) begin
               miscompares++;
               $display("FAIL random_addr cyc%0d: got %h srv=%0d", cyc, l2_address, m_srv);
            end
         end
         vectors++;
         if (l2_wdata !== dcache_pmem_wdata || icache_pmem_rdata !== l2_rdata || dcache_pmem_rdata !== l2_rdata) begin
            miscompares++;
            $display("FAIL random_data cyc%0d: wdata=%h rdata_i=%h rdata_d=%h", cyc,
                     l2_wdata, icache_pmem_rdata, dcache_pmem_rdata);
         end
         vectors++;
         if (arb_conflict_count !== CW'(m_cnt)) begin
            miscompares++;
            $display("FAIL random_count cyc%0d: got %0d want %0d", cyc, arb_conflict_count, m_cnt);
         end
         if (exp_ir) i_act = 0;
         if (exp_dr) d_act = 0;
         model_step();
      end
      clear_inputs();
      do_reset();
   endtask

   task automatic test_saturate();
      int want;
      do_reset();
      icache_pmem_read = 1'b1;
      dcache_pmem_read = 1'b1;
      l2_resp          = 1'b1;
      for (int k = 0; k < 2 * CNT_MAX + 40; k++) begin
         #1;
         want = (k + 1) / 2;
         if (want > CNT_MAX) want = CNT_MAX;
         vectors++;
         if (arb_conflict_count !== CW'(want)) begin
            miscompares++;
            $display("FAIL saturate_k%0d: got %0d want %0d", k, arb_conflict_count, want);
         end
         model_step();
      end
      #1;
      vectors++;
      if (arb_conflict_count !== {CW{1'b1}}) begin
         miscompares++;
         $display("FAIL saturate_final: got %h want all-ones", arb_conflict_count);
      end
      clear_inputs();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      clear_inputs();
      model_reset();
      test_reset();
      test_icache_read();
      test_dcache_write();
      test_tie();
      test_alternate();
      test_reset_midflight();
      test_random();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
